// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
//
// Control FSM for the multi-cycle MIPS core. It sequences the shared datapath
// (single cache port, one ALU, IR/A/B/ALUOut) through fetch, decode, execute,
// memory and writeback steps. It stalls on the cache mem_ready handshake and
// pulses 'illegal' for unsupported opcodes.
//
// Build option:
//   MULTICTRL_ADDI_EN  defined   -> addi (001000) runs DECODE -> IEXEC -> IWB
//                      undefined -> addi is illegal; IEXEC/IWB are not built
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   synchronous active-low reset
//   opCode[5:0]  in   IR[31:26], sampled in DECODE only
//   mem_ready    in   cache finished current read/write this cycle
//   pcWrite      out  unconditional PC load
//   pcWriteCond  out  PC load if ALU zero (beq)
//   IorD         out  memory address select: 0 = PC, 1 = ALUOut
//   memRead      out  cache read request
//   memWrite     out  cache write request
//   irWrite      out  load IR from memory data
//   memtoReg     out  regfile write data: 0 = ALUOut, 1 = MDR
//   regDst       out  write register: 0 = rt, 1 = rd
//   regWrite     out  regfile write enable
//   ALUSrcA      out  0 = PC, 1 = A
//   ALUSrcB[1:0] out  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   ALUOp[1:0]   out  00 = add, 01 = sub, 10 = funct decode
//   pcSource[1:0]out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   instr_done   out  pulse on an instruction's final cycle
//   illegal      out  pulse when an unsupported opcode is seen in DECODE
//   state[3:0]   out  current state encoding (debug)
//
// state  | code | meaning
// -------+------+-----------------------------------------------
// FETCH  |  0   | read instruction, PC+4; wait on mem_ready
// DECODE |  1   | branch target into ALUOut, dispatch on opcode
// MEMADR |  2   | effective address for lw/sw
// MEMRD  |  3   | load data read; wait on mem_ready
// MEMWB  |  4   | load writeback from MDR
// MEMWR  |  5   | store write; wait on mem_ready
// EXEC   |  6   | R-type ALU operation
// RWB    |  7   | R-type writeback to rd
// BRANCH |  8   | beq compare and conditional PC load
// JUMP   |  9   | PC <= jump target
// IEXEC  | 10   | addi ALU operation (MULTICTRL_ADDI_EN only)
// IWB    | 11   | addi writeback to rt (MULTICTRL_ADDI_EN only)
// ============================================================================
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] pcSource,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MULTICTRL_ADDI_EN
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;
`endif

    // Opcode class, decoded in DECODE and latched so later states do not
    // depend on opCode staying stable.
    localparam logic [2:0] CLS_NONE  = 3'd0;
    localparam logic [2:0] CLS_RTYPE = 3'd1;
    localparam logic [2:0] CLS_LW    = 3'd2;
    localparam logic [2:0] CLS_SW    = 3'd3;
    localparam logic [2:0] CLS_BEQ   = 3'd4;
    localparam logic [2:0] CLS_J     = 3'd5;
`ifdef MULTICTRL_ADDI_EN
    localparam logic [2:0] CLS_ADDI  = 3'd6;
`endif
    localparam logic [2:0] CLS_ILL   = 3'd7;

    logic [3:0] state_q, state_d;
    logic [2:0] cls_q, cls_d;
    logic [2:0] dec_cls;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_cls = CLS_ILL;
        case (opCode)
            6'b000000: dec_cls = CLS_RTYPE;
            6'b100011: dec_cls = CLS_LW;
            6'b101011: dec_cls = CLS_SW;
            6'b000100: dec_cls = CLS_BEQ;
            6'b000010: dec_cls = CLS_J;
`ifdef MULTICTRL_ADDI_EN
            6'b001000: dec_cls = CLS_ADDI;
`endif
            default:   dec_cls = CLS_ILL;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        cls_d   = cls_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CLS_RTYPE: state_d = S_EXEC;
                    CLS_LW,
                    CLS_SW:    state_d = S_MEMADR;
                    CLS_BEQ:   state_d = S_BRANCH;
                    CLS_J:     state_d = S_JUMP;
`ifdef MULTICTRL_ADDI_EN
                    CLS_ADDI:  state_d = S_IEXEC;
`endif
                    default:   state_d = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR; anything else is a corrupted class
            // and is recovered by refetching.
            S_MEMADR: begin
                if (cls_q == CLS_LW)
                    state_d = S_MEMRD;
                else if (cls_q == CLS_SW)
                    state_d = S_MEMWR;
                else
                    state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MULTICTRL_ADDI_EN
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Everything defaults to 0; reset overrides all of it so
    // no write strobe can escape during the cycle rst_n is low.
    // ------------------------------------------------------------------
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        pcSource    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    ALUSrcB = 2'b01;
                    irWrite = mem_ready;
                    pcWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal    = (dec_cls == CLS_ILL);
                    instr_done = (dec_cls == CLS_ILL);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    regWrite   = 1'b1;
                    memtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    memWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    regWrite   = 1'b1;
                    regDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    pcWrite    = 1'b1;
                    pcSource   = 2'b10;
                    instr_done = 1'b1;
                end
`ifdef MULTICTRL_ADDI_EN
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_IWB: begin
                    regWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opCode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pcWrite, pcWriteCond, IorD, memRead, memWrite, irWrite;
    logic       memtoReg, regDst, regWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, pcSource;
    logic       instr_done, illegal;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memtoReg(memtoReg), .regDst(regDst), .regWrite(regWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .pcSource(pcSource), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcWrite, pcWriteCond, IorD, memRead, memWrite, irWrite;
        logic       memtoReg, regDst, regWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, pcSource;
        logic       instr_done, illegal;
        logic [3:0] state;
    } ctl_t;

    ctl_t act;
    assign act = {pcWrite, pcWriteCond, IorD, memRead, memWrite, irWrite,
                  memtoReg, regDst, regWrite, ALUSrcA, ALUSrcB, ALUOp,
                  pcSource, instr_done, illegal, state};

    int    checks = 0;
    int    errors = 0;
    ctl_t  exp_v;
    bit    chk_en = 1'b0;
    string exp_tag = "";

    // Event counters observed independently of the per-cycle model.
    int memwr_cnt = 0, done_cnt = 0, regwr_cnt = 0, ill_cnt = 0;

    // Controller behaviour from the state table: what each step drives.
    function automatic ctl_t model(int st, bit mr, bit rstn, bit bad);
        ctl_t e;
        e = '0;
        e.state = st[3:0];
        if (!rstn) return e;
        case (st)
            0:  begin e.memRead = 1; e.ALUSrcB = 2'b01; e.irWrite = mr; e.pcWrite = mr; end
            1:  begin e.ALUSrcB = 2'b11; e.illegal = bad; e.instr_done = bad; end
            2:  begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            3:  begin e.memRead = 1; e.IorD = 1; end
            4:  begin e.regWrite = 1; e.memtoReg = 1; e.instr_done = 1; end
            5:  begin e.memWrite = 1; e.IorD = 1; e.instr_done = mr; end
            6:  begin e.ALUSrcA = 1; e.ALUOp = 2'b10; end
            7:  begin e.regWrite = 1; e.regDst = 1; e.instr_done = 1; end
            8:  begin e.ALUSrcA = 1; e.ALUOp = 2'b01; e.pcWriteCond = 1;
                      e.pcSource = 2'b01; e.instr_done = 1; end
            9:  begin e.pcWrite = 1; e.pcSource = 2'b10; e.instr_done = 1; end
            10: begin e.ALUSrcA = 1; e.ALUSrcB = 2'b10; end
            11: begin e.regWrite = 1; e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s @%0t: got %h want %h (state got %0d want %0d)",
                         exp_tag, $time, act, exp_v, act.state, exp_v.state);
            end
            if (memWrite && IorD) memwr_cnt++;
            if (instr_done)       done_cnt++;
            if (regWrite)         regwr_cnt++;
            if (illegal)          ill_cnt++;
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, set expectation.
    task automatic cyc(input int st, input bit mr, input bit rstn, input bit bad,
                       input logic [5:0] op, input string tag);
        @(posedge clk);
        #1;
        mem_ready = mr;
        rst_n     = rstn;
        opCode    = op;
        exp_v     = model(st, mr, rstn, bad);
        exp_tag   = tag;
        chk_en    = 1'b1;
    endtask

    // Instruction-level sequence; mem_ready is held low in non-memory steps
    // to show it does not stall them.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input string tag, output int ncyc);
        bit bad;
        logic [5:0] junk;
        junk = ~op;
        ncyc = 0;
        bad  = 1'b0;
        repeat (fw) begin cyc(0, 0, 1, 0, op, tag); ncyc++; end
        cyc(0, 1, 1, 0, op, tag); ncyc++;
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: bad = 1'b0;
`ifdef MULTICTRL_ADDI_EN
            6'b001000: bad = 1'b0;
`endif
            default: bad = 1'b1;
        endcase
        cyc(1, 0, 1, bad, op, tag); ncyc++;
        if (!bad) begin
            case (op)
                6'b100011: begin
                    cyc(2, 0, 1, 0, junk, tag); ncyc++;
                    repeat (mw) begin cyc(3, 0, 1, 0, junk, tag); ncyc++; end
                    cyc(3, 1, 1, 0, junk, tag); ncyc++;
                    cyc(4, 0, 1, 0, junk, tag); ncyc++;
                end
                6'b101011: begin
                    cyc(2, 0, 1, 0, junk, tag); ncyc++;
                    repeat (mw) begin cyc(5, 0, 1, 0, junk, tag); ncyc++; end
                    cyc(5, 1, 1, 0, junk, tag); ncyc++;
                end
                6'b000000: begin
                    cyc(6, 0, 1, 0, op, tag); ncyc++;
                    cyc(7, 0, 1, 0, op, tag); ncyc++;
                end
                6'b000100: begin cyc(8, 0, 1, 0, op, tag); ncyc++; end
                6'b000010: begin cyc(9, 0, 1, 0, op, tag); ncyc++; end
                default: begin
                    cyc(10, 0, 1, 0, op, tag); ncyc++;
                    cyc(11, 0, 1, 0, op, tag); ncyc++;
                end
            endcase
        end
    endtask

    // Wait until the compare process has consumed the last cycle.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n, mw0, d0, r0, i0;

        // Reset for two edges with mem_ready high.
        cyc(0, 1, 0, 0, 6'b100011, "reset");
        #2; chk("reset_memRead", memRead, 0);
        cyc(0, 1, 0, 0, 6'b100011, "reset");
        #2; chk("reset_state", state, 0);
        chk("reset_irWrite", irWrite, 0);

        // lw, no waits; first fetch after release.
        r0 = regwr_cnt; d0 = done_cnt;
        run_instr(6'b100011, 0, 0, "lw", n);
        settle();
        chk("lw_cycles", n, 5);
        chk("lw_regWrite_cycles", regwr_cnt - r0, 1);
        chk("lw_done_pulses", done_cnt - d0, 1);

        // sw with 3 cache wait cycles in MEMWR.
        mw0 = memwr_cnt; d0 = done_cnt;
        run_instr(6'b101011, 0, 3, "sw_wait3", n);
        settle();
        chk("sw_cycles", n, 7);
        chk("sw_memWrite_cycles", memwr_cnt - mw0, 4);
        chk("sw_done_pulses", done_cnt - d0, 1);

        // lw with fetch and read waits.
        run_instr(6'b100011, 2, 1, "lw_waits", n);
        chk("lw_waits_cycles", n, 8);

        run_instr(6'b000000, 0, 0, "rtype", n);
        chk("rtype_cycles", n, 4);
        run_instr(6'b000100, 0, 0, "beq", n);
        chk("beq_cycles", n, 3);
        run_instr(6'b000010, 1, 0, "j", n);
        chk("j_cycles", n, 4);

        // addi: builds differently with the macro.
        r0 = regwr_cnt; i0 = ill_cnt;
        run_instr(6'b001000, 0, 0, "addi", n);
        settle();
`ifdef MULTICTRL_ADDI_EN
        chk("addi_cycles", n, 4);
        chk("addi_regWrite", regwr_cnt - r0, 1);
        chk("addi_illegal", ill_cnt - i0, 0);
`else
        chk("addi_cycles", n, 2);
        chk("addi_regWrite", regwr_cnt - r0, 0);
        chk("addi_illegal", ill_cnt - i0, 1);
`endif

        // Unsupported opcode.
        i0 = ill_cnt;
        run_instr(6'b111111, 0, 0, "illegal", n);
        settle();
        chk("illegal_cycles", n, 2);
        chk("illegal_pulses", ill_cnt - i0, 1);

        // Reset during MEMRD wait aborts the load.
        r0 = regwr_cnt;
        cyc(0, 1, 1, 0, 6'b100011, "abort");
        cyc(1, 0, 1, 0, 6'b100011, "abort");
        cyc(2, 0, 1, 0, 6'b000000, "abort");
        cyc(3, 0, 1, 0, 6'b000000, "abort");
        cyc(3, 0, 1, 0, 6'b000000, "abort");
        cyc(3, 1, 0, 0, 6'b000000, "abort_rst");
        #2; chk("abort_memRead_in_reset", memRead, 0);
        run_instr(6'b000010, 0, 0, "after_abort", n);
        settle();
        chk("abort_regWrite", regwr_cnt - r0, 0);
        chk("after_abort_cycles", n, 3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
